// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle MIPS controller. The FSM steps through FETCH, DECODE, EXECUTE,
//   MEMORY and WRITEBACK, and uses a req/ready handshake to a variable-latency
//   unified memory port. It supports load/store, J/JAL/JR, sign-based branches,
//   a sticky halt and a watchdog on memory stalls.
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   opcode, func        fields from the instruction register
//   zero, negative      ALU flags, sampled only in EXECUTE
//   mem_ready           memory completes the current request this cycle
//   mem_req             memory request valid
//   mem_write_en        request is a write
//   ir_write, pc_write  IR / PC load strobes
//   pc_src              0=PC+4 1=branch target 2=jump target 3=rs
//   alu_src, reg_dest, link, mem_or_reg, reg_write_enable, is_unsigned
//                       datapath selects
//   alu_operation       ADD=0 SUB=1 AND=2 OR=3 SLT=4
//   halted              sticky halt
//   wdog_error          sticky memory-stall watchdog trip
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int FUNC_W   = 6,
    parameter int ALU_OP_W = 4,
    parameter int WDOG_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                zero,
    input  logic                negative,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write_en,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src,
    output logic                reg_dest,
    output logic                link,
    output logic                mem_or_reg,
    output logic                reg_write_enable,
    output logic                is_unsigned,
    output logic [ALU_OP_W-1:0] alu_operation,
    output logic                halted,
    output logic                wdog_error
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEMORY  = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_BLEZ  = OPCODE_W'(6'b000110);
    localparam logic [OPCODE_W-1:0] OP_BGTZ  = OPCODE_W'(6'b000111);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'(6'b001001);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    localparam logic [FUNC_W-1:0] FN_SYSCALL = FUNC_W'(6'b001100);
    localparam logic [FUNC_W-1:0] FN_JR      = FUNC_W'(6'b001000);
    localparam logic [FUNC_W-1:0] FN_ADD     = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] FN_SUB     = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] FN_AND     = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] FN_OR      = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] FN_SLT     = FUNC_W'(6'b101010);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

    // A zero-width watchdog still needs a 1-bit counter to stay legal; it is
    // simply never enabled.
    localparam bit                WDOG_EN  = (WDOG_W > 0);
    localparam int                CNT_W    = (WDOG_W > 0) ? WDOG_W : 1;
    localparam logic [CNT_W-1:0]  CNT_ONES = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_ONES - CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             wdog_q, wdog_d;
    logic             req_state, stall, wdog_fire;
    logic             is_branch, taken;

    function automatic logic [ALU_OP_W-1:0] alu_from_funct(input logic [FUNC_W-1:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Only FETCH and MEMORY present a request, so mem_ready elsewhere is ignored.
    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMORY);
    assign stall     = req_state && !mem_ready;
    // Fires on the stall cycle that brings the count to all-ones.
    assign wdog_fire = WDOG_EN && stall && (wcnt_q == CNT_LAST);

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                       (opcode == OP_BLEZ) || (opcode == OP_BGTZ);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            OP_BLEZ: taken = zero || negative;
            OP_BGTZ: taken = !zero && !negative;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        mem_write_en     = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 2'd0;
        alu_src          = 1'b0;
        reg_dest         = 1'b0;
        link             = 1'b0;
        mem_or_reg       = 1'b0;
        reg_write_enable = 1'b0;
        is_unsigned      = 1'b0;
        alu_operation    = ALU_ADD;
        halted           = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
                case (opcode)
                    OP_RTYPE: begin
                        case (func)
                            FN_SYSCALL: state_d = S_HALT;
                            FN_JR: begin
                                pc_write = 1'b1;
                                pc_src   = 2'd3;
                                state_d  = S_FETCH;
                            end
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_EXECUTE;
                            default: state_d = S_FETCH;   // unknown funct: NOP
                        endcase
                    end
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write         = 1'b1;
                        pc_src           = 2'd2;
                        link             = 1'b1;
                        reg_write_enable = 1'b1;
                        state_d          = S_FETCH;
                    end
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                    OP_ADDI, OP_ADDIU, OP_LW, OP_SW: state_d = S_EXECUTE;
                    default: state_d = S_FETCH;           // unknown opcode: NOP
                endcase
            end
            S_EXECUTE: begin
                if (opcode == OP_RTYPE) begin
                    alu_operation = alu_from_funct(func);
                    state_d       = S_WB;
                end else if (is_branch) begin
                    alu_operation = ALU_SUB;
                    if (taken) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                    end
                    state_d = S_FETCH;
                end else begin
                    alu_src     = 1'b1;
                    is_unsigned = (opcode == OP_ADDIU);
                    state_d     = ((opcode == OP_LW) || (opcode == OP_SW)) ? S_MEMORY : S_WB;
                end
            end
            S_MEMORY: begin
                mem_req      = 1'b1;
                mem_write_en = (opcode == OP_SW);
                if (mem_ready) state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_write_enable = 1'b1;
                reg_dest         = (opcode == OP_RTYPE);
                mem_or_reg       = (opcode == OP_LW);
                state_d          = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
        if (wdog_fire) state_d = S_HALT;
        // Outputs read zero for as long as reset is held, not only after it.
        if (reset) begin
            mem_req          = 1'b0;
            mem_write_en     = 1'b0;
            ir_write         = 1'b0;
            pc_write         = 1'b0;
            pc_src           = 2'd0;
            alu_src          = 1'b0;
            reg_dest         = 1'b0;
            link             = 1'b0;
            mem_or_reg       = 1'b0;
            reg_write_enable = 1'b0;
            is_unsigned      = 1'b0;
            alu_operation    = ALU_ADD;
            halted           = 1'b0;
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (!WDOG_EN || !stall) wcnt_d = '0;
        else if (wcnt_q != CNT_ONES) wcnt_d = wcnt_q + CNT_W'(1);
        wdog_d = wdog_q || wdog_fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
            wdog_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wdog_q  <= wdog_d;
        end
    end

    assign wdog_error = wdog_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero, negative, mem_ready;
    logic       mem_req, mem_write_en, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src, reg_dest, link, mem_or_reg, reg_write_enable, is_unsigned;
    logic [3:0] alu_operation;
    logic       halted, wdog_error;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OPCODE_W(6), .FUNC_W(6), .ALU_OP_W(4), .WDOG_W(4)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func),
        .zero(zero), .negative(negative), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
        .reg_dest(reg_dest), .link(link), .mem_or_reg(mem_or_reg),
        .reg_write_enable(reg_write_enable), .is_unsigned(is_unsigned),
        .alu_operation(alu_operation), .halted(halted), .wdog_error(wdog_error)
    );

    // {mem_req, mem_write_en, ir_write, pc_write, pc_src, alu_src, reg_dest,
    //  link, mem_or_reg, reg_write_enable, is_unsigned, alu_operation, halted, wdog_error}
    logic [16:0] got;
    assign got = {mem_req, mem_write_en, ir_write, pc_write, pc_src, alu_src, reg_dest,
                  link, mem_or_reg, reg_write_enable, is_unsigned, alu_operation,
                  halted, wdog_error};

    typedef struct {
        logic [16:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [16:0] ev(input logic mreq, input logic mwe, input logic irw,
                                       input logic pcw, input logic [1:0] psrc,
                                       input logic asrc, input logic rdst, input logic lnk,
                                       input logic mor, input logic rwe, input logic uns,
                                       input logic [3:0] aop, input logic hlt,
                                       input logic wde);
        return {mreq, mwe, irw, pcw, psrc, asrc, rdst, lnk, mor, rwe, uns, aop, hlt, wde};
    endfunction

    localparam logic [5:0] RT = 6'b000000, J = 6'b000010, JAL = 6'b000011,
                           BEQ = 6'b000100, BNE = 6'b000101, BLEZ = 6'b000110,
                           BGTZ = 6'b000111, ADDI = 6'b001000, ADDIU = 6'b001001,
                           LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] F_SYS = 6'b001100, F_JR = 6'b001000, F_SUB = 6'b100010,
                           F_SLT = 6'b101010, F_OR = 6'b100101;

    logic [16:0] Z, FRDY, FWAIT;

    // Monitor: one expected entry per cycle in which the stimulus pushed one.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b expected=%b (t=%0t)", e.nm, got, e.v, $time);
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic n, input logic r, input logic [16:0] ex,
                         input string nm);
        exp_t e;
        opcode    = op;
        func      = fn;
        zero      = z;
        negative  = n;
        mem_ready = r;
        e.v  = ex;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic n, input logic r, input logic [16:0] ex,
                        input string nm);
        @(posedge clk);
        #1;
        drive(op, fn, z, n, r, ex, nm);
    endtask

    task automatic async_reset(input string nm);
        exp_t e;
        @(posedge clk);
        #3;
        reset = 1'b1;
        e.v  = '0;
        e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        Z     = '0;
        FRDY  = ev(1,0,1,1,2'd0,0,0,0,0,0,0,4'd0,0,0);
        FWAIT = ev(1,0,0,0,2'd0,0,0,0,0,0,0,4'd0,0,0);
        reset = 1'b1;
        opcode = '0; func = '0; zero = 0; negative = 0; mem_ready = 1'b1;
        #1;
        drive(RT, 6'd0, 0, 0, 1, Z, "reset_outputs");
        @(negedge clk);
        @(posedge clk); #1; reset = 1'b0;

        // ADDI: FETCH, DECODE, EXECUTE, WRITEBACK
        drive(ADDI, 0, 0, 0, 1, FRDY, "addi_fetch");
        step (ADDI, 0, 0, 0, 1, Z, "addi_decode");
        step (ADDI, 0, 0, 0, 1, ev(0,0,0,0,2'd0,1,0,0,0,0,0,4'd0,0,0), "addi_exec");
        step (ADDI, 0, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,1,0,4'd0,0,0), "addi_wb");

        // LW with three stall cycles in MEMORY (8 cycles total)
        step (LW, 0, 0, 0, 1, FRDY, "lw_fetch");
        step (LW, 0, 0, 0, 1, Z, "lw_decode");
        step (LW, 0, 0, 0, 1, ev(0,0,0,0,2'd0,1,0,0,0,0,0,4'd0,0,0), "lw_exec");
        for (int i = 0; i < 3; i++)
            step(LW, 0, 0, 0, 0, FWAIT, "lw_mem_stall");
        step (LW, 0, 0, 0, 1, FWAIT, "lw_mem_done");
        step (LW, 0, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,1,1,0,4'd0,0,0), "lw_wb");

        // SW with fetch stalls: MEMORY write goes straight back to FETCH
        step (SW, 0, 0, 0, 0, FWAIT, "sw_fetch_stall");
        step (SW, 0, 0, 0, 1, FRDY, "sw_fetch");
        step (SW, 0, 0, 0, 1, Z, "sw_decode");
        step (SW, 0, 0, 0, 1, ev(0,0,0,0,2'd0,1,0,0,0,0,0,4'd0,0,0), "sw_exec");
        step (SW, 0, 0, 0, 1, ev(1,1,0,0,2'd0,0,0,0,0,0,0,4'd0,0,0), "sw_mem");

        // BLEZ taken on negative, BGTZ not taken on same flags, BNE not taken on zero
        step (BLEZ, 0, 0, 1, 1, FRDY, "blez_fetch");
        step (BLEZ, 0, 0, 1, 1, Z, "blez_decode");
        step (BLEZ, 0, 0, 1, 1, ev(0,0,0,1,2'd1,0,0,0,0,0,0,4'd1,0,0), "blez_exec_taken");
        step (BGTZ, 0, 0, 1, 1, FRDY, "bgtz_fetch");
        step (BGTZ, 0, 0, 1, 1, Z, "bgtz_decode");
        step (BGTZ, 0, 0, 1, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd1,0,0), "bgtz_exec_not_taken");
        step (BNE, 0, 1, 0, 1, FRDY, "bne_fetch");
        step (BNE, 0, 1, 0, 1, Z, "bne_decode");
        step (BNE, 0, 1, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd1,0,0), "bne_exec_not_taken");
        step (BEQ, 0, 1, 0, 1, FRDY, "beq_fetch");
        step (BEQ, 0, 1, 0, 1, Z, "beq_decode");
        step (BEQ, 0, 1, 0, 1, ev(0,0,0,1,2'd1,0,0,0,0,0,0,4'd1,0,0), "beq_exec_taken");

        // JAL, J and JR resolve in DECODE
        step (JAL, 0, 0, 0, 1, FRDY, "jal_fetch");
        step (JAL, 0, 0, 0, 1, ev(0,0,0,1,2'd2,0,0,1,0,1,0,4'd0,0,0), "jal_decode");
        step (J, 0, 0, 0, 1, FRDY, "j_fetch");
        step (J, 0, 0, 0, 1, ev(0,0,0,1,2'd2,0,0,0,0,0,0,4'd0,0,0), "j_decode");
        step (RT, F_JR, 0, 0, 1, FRDY, "jr_fetch");
        step (RT, F_JR, 0, 0, 1, ev(0,0,0,1,2'd3,0,0,0,0,0,0,4'd0,0,0), "jr_decode");

        // R-type SUB / SLT / OR with reg_dest in WRITEBACK; ADDIU unsigned
        step (RT, F_SUB, 0, 0, 1, FRDY, "sub_fetch");
        step (RT, F_SUB, 0, 0, 1, Z, "sub_decode");
        step (RT, F_SUB, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd1,0,0), "sub_exec");
        step (RT, F_SUB, 0, 0, 1, ev(0,0,0,0,2'd0,0,1,0,0,1,0,4'd0,0,0), "sub_wb");
        step (RT, F_SLT, 0, 0, 1, FRDY, "slt_fetch");
        step (RT, F_SLT, 0, 0, 1, Z, "slt_decode");
        step (RT, F_SLT, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd4,0,0), "slt_exec");
        step (RT, F_SLT, 0, 0, 1, ev(0,0,0,0,2'd0,0,1,0,0,1,0,4'd0,0,0), "slt_wb");
        step (RT, F_OR, 0, 0, 1, FRDY, "or_fetch");
        step (RT, F_OR, 0, 0, 1, Z, "or_decode");
        step (RT, F_OR, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd3,0,0), "or_exec");
        step (RT, F_OR, 0, 0, 1, ev(0,0,0,0,2'd0,0,1,0,0,1,0,4'd0,0,0), "or_wb");
        step (ADDIU, 0, 0, 0, 1, FRDY, "addiu_fetch");
        step (ADDIU, 0, 0, 0, 1, Z, "addiu_decode");
        step (ADDIU, 0, 0, 0, 1, ev(0,0,0,0,2'd0,1,0,0,0,0,1,4'd0,0,0), "addiu_exec");
        step (ADDIU, 0, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,1,0,4'd0,0,0), "addiu_wb");

        // Unknown opcode is a NOP: DECODE returns to FETCH
        step (6'b111111, 0, 0, 0, 1, FRDY, "nop_fetch");
        step (6'b111111, 0, 0, 0, 1, Z, "nop_decode");

        // SYSCALL halts; mem_ready pulses are ignored
        step (RT, F_SYS, 0, 0, 1, FRDY, "sys_fetch");
        step (RT, F_SYS, 0, 0, 1, Z, "sys_decode");
        step (RT, F_SYS, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd0,1,0), "halt_ready_hi");
        step (RT, F_SYS, 0, 0, 0, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd0,1,0), "halt_ready_lo");
        step (ADDI, 0, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd0,1,0), "halt_sticky");
        async_reset("reset_mid_halt");

        // Release into FETCH with memory never ready: watchdog trips after 15 stalls
        @(posedge clk); #1; reset = 1'b0;
        drive(ADDI, 0, 0, 0, 0, FWAIT, "wdog_stall");
        for (int i = 0; i < 14; i++)
            step(ADDI, 0, 0, 0, 0, FWAIT, "wdog_stall");
        step (ADDI, 0, 0, 0, 0, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd0,1,1), "wdog_trip");
        step (ADDI, 0, 0, 0, 1, ev(0,0,0,0,2'd0,0,0,0,0,0,0,4'd0,1,1), "wdog_sticky");
        async_reset("reset_clears_wdog");

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
